// File: rtl/fir_pkg.sv
// Shared FIR constants and types: default word width and tap count, the psum word type,
// and the bit order of the FIFO status vector used for monitor concatenation.
package fir_pkg;

  localparam int unsigned FIR_DW = 16;
  localparam int unsigned FIR_M  = 4;

  typedef logic [FIR_DW-1:0] psum_t;

  // Status vector order {full, empty, overflow, underflow}
  localparam int unsigned ST_WIDTH     = 4;
  localparam int unsigned ST_FULL      = 3;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVERFLOW  = 1;
  localparam int unsigned ST_UNDERFLOW = 0;

  function automatic logic [ST_WIDTH-1:0] fifo_status(input logic f, input logic e,
                                                      input logic o, input logic u);
    logic [ST_WIDTH-1:0] s;
    s               = '0;
    s[ST_FULL]      = f;
    s[ST_EMPTY]     = e;
    s[ST_OVERFLOW]  = o;
    s[ST_UNDERFLOW] = u;
    return s;
  endfunction

endpackage

// File: rtl/fir_wrap_ptr.sv
// AW-bit circular pointer with increment enable; wraps from DEPTH-1 to 0 so DEPTH
// need not be a power of two.
module fir_wrap_ptr #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_psum_fifo.sv
// Partial-sum FIFO between FIR tap passes, with occupancy and sticky error flags.
// FIR_PSUM_FIFO_FWFT_EN selects first-word-fall-through output instead of a registered read.
module fir_psum_fifo
  import fir_pkg::*;
#(
  parameter int DW = FIR_DW,
  parameter int DEPTH = FIR_M,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FIFO_write,
  input  logic          FIFO_read,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write
  assign rd_ok = FIFO_read & ~empty;
  assign wr_ok = FIFO_write & (~full | rd_ok);

  fir_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (wr_ok),
    .ptr   (wr_ptr)
  );

  fir_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (rd_ok),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      overflow  <= (overflow  & ~clr_err) | (FIFO_write & ~wr_ok);
      underflow <= (underflow & ~clr_err) | (FIFO_read  & ~rd_ok);
    end
  end

`ifdef FIR_PSUM_FIFO_FWFT_EN
  assign dout       = mem[rd_ptr];
  assign dout_valid = ~empty;
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) begin
        dout <= mem[rd_ptr];
      end
    end
  end
`endif

endmodule

// File: doc/fir_psum_fifo.md
Name: fir_psum_fifo

Overview:
- Partial-sum buffer serving the FIR datapath. It is the responder to the controller's FIFO_write/FIFO_read strobes.
- Stores DEPTH words of DW-bit accumulator data between tap passes. Returns them in order to the mux2 input of the MAC.
- Reports occupancy, full/empty, and sticky overflow/underflow errors so the controller sequencing can be checked at runtime.

Parameters:
- DW, 16, data word width (partial-sum width)
- DEPTH, 4, number of storage entries; matches the controller's tap count M; legal range 2..64, need not be a power of two
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- FIFO_write  in  1  write strobe from controller
- FIFO_read  in  1  read strobe from controller
- din  in  DW  write data (dmux output)
- dout  out  DW  read data to mux2
- dout_valid  out  1  dout holds a freshly read word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was refused
- clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (RST low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. This gives empty=1, full=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all stored words immediately. There is no drain.
- Write accept: wr_ok = FIFO_write & (~full | rd_ok). A word is written to mem[wr_ptr]. wr_ptr advances, wrapping from DEPTH-1 to 0.
- Read accept: rd_ok = FIFO_read & ~empty. On the next edge, dout <= mem[rd_ptr] and dout_valid <= 1. rd_ptr wraps as wr_ptr does. Read latency is 1 cycle.
- No read accepted: dout holds its previous value; dout_valid <= 0.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Simultaneous read+write when full: both are accepted, count stays at DEPTH, no overflow.
- Simultaneous read+write when empty: the read is refused (underflow set) and the write is accepted (count -> 1). There is no write-to-read bypass.
- FIFO_write when full and no read: data is dropped, overflow <= 1, pointers unchanged.
- FIFO_read when empty: underflow <= 1, dout unchanged, dout_valid <= 0.
- Sticky flags: clr_err clears both flags on the next edge. If an error event occurs in the same cycle, the flag stays set (set wins).
- full/empty are combinational decodes of registered count.
- No arithmetic on data; words pass through bit-exact.

Optional Feature:
- Macro: FIR_PSUM_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally and dout_valid = ~empty.
  - FIFO_read pops the current head; the next word appears in the same cycle after the edge.
  - Read latency 0.
  - The empty-read and underflow rules are unchanged.
- Undefined: registered 1-cycle read as specified above.

Decomposition:
- Package fir_pkg holds:
  - the default DW/DEPTH constants shared with the controller
  - a typedef for the psum word (logic [DW-1:0])
  - localparams for the FIFO status vector order {full, empty, overflow, underflow}, used for monitor concatenation like controller_monitor
- One sub-module, fir_wrap_ptr: an AW-bit pointer with an increment enable that wraps at DEPTH-1. It is instantiated twice, for wr and rd.

Test Plan:
- Reset then write 4 words 0x0011,0x0022,0x0033,0x0044 (DEPTH=4) -> count=4, full=1, empty=0. Then 4 reads -> dout 0x0011..0x0044, each one cycle after its strobe, empty=1.
- While full, assert FIFO_write with din=0x0055 and no read -> overflow=1, count=4. Subsequent reads return 0x0011 first, and 0x0055 never appears.
- Full, then 6 cycles of simultaneous read+write with din=0x0100..0x0105 -> count stays 4, no overflow. Output order is 0x0011,0x0022,0x0033,0x0044,0x0100,0x0101 (pointer wrap verified).
- Empty, then simultaneous read+write with din=0x0AAA -> underflow=1, dout_valid=0, count=1. The next read returns 0x0AAA.
- Write 3 words, then pull RST low between clock edges -> count=0, empty=1, dout=0 immediately. After release, a read sets underflow.
- Pulse clr_err with overflow=1 -> cleared next edge. A clr_err coincident with a new empty-read -> underflow remains 1.
